// File: rtl/rc4_sched_if.sv
// Bus bundle for the RC4 sequencer: key byte stream, data in/out streams and
// the single read/write port of the external 256x8 S-box RAM.
interface rc4_sched_if;
   logic       key_rvalid;
   logic       key_rready;
   logic [7:0] key_in;
   logic       data_rvalid;
   logic       data_rready;
   logic [7:0] data_in;
   logic       data_wvalid;
   logic       data_wready;
   logic [7:0] data_out;
   logic [7:0] sbox_addr;
   logic       sbox_we;
   logic [7:0] sbox_wdata;
   logic [7:0] sbox_rdata;

   modport master (
      input  key_rvalid, key_in, data_rvalid, data_in, data_wready, sbox_rdata,
      output key_rready, data_rready, data_wvalid, data_out, sbox_addr, sbox_we, sbox_wdata
   );

   modport slave (
      output key_rvalid, key_in, data_rvalid, data_in, data_wready, sbox_rdata,
      input  key_rready, data_rready, data_wvalid, data_out, sbox_addr, sbox_we, sbox_wdata
   );
endinterface

// File: rtl/rc4_sched.sv
// RC4 sequencer: key load, S-box init and KSA on an external synchronous RAM,
// then PRGA one byte per data handshake with the keystream XORed into the data.
module rc4_sched #(
   parameter int KEY_MAX = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [8:0]   key_len,
   output logic         ready,
   output logic         err,
   rc4_sched_if.master  bus
);

   localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

   typedef enum logic [3:0] {
      IDLE, LOAD, INIT, KSA_A, KSA_B, KSA_C, KSA_D, READY,
      P_ACC, P1, P2, P3, P4, P5, P6, P_OUT
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    i, j, si, sj;
   logic [KW-1:0] kidx;
   logic [8:0]    len;
   logic [7:0]    din, dout;
   logic [7:0]    key_buf [KEY_MAX];

   logic       len_ok, start_ok, key_fire, key_last;
   logic [7:0] j_ksa, j_prga;
   logic [7:0] addr_c, wdata_c;
   logic       we_c;

   assign len_ok   = (key_len != 9'd0) && (key_len <= 9'(KEY_MAX));
   assign start_ok = start && len_ok && (state == IDLE || state == READY);
   assign key_fire = (state == LOAD) && bus.key_rvalid;
   // Same compare serves as "last key byte" in LOAD and "key index wraps" in KSA.
   assign key_last = (9'(kidx) == len - 9'd1);
   assign j_ksa    = j + bus.sbox_rdata + key_buf[kidx];
   assign j_prga   = j + bus.sbox_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      addr_c    = 8'd0;
      we_c      = 1'b0;
      wdata_c   = 8'd0;
      case (state)
         IDLE:  if (start_ok) state_nxt = LOAD;
         LOAD:  if (key_fire && key_last) state_nxt = INIT;
         INIT: begin
            addr_c  = i;
            we_c    = 1'b1;
            wdata_c = i;
            if (i == 8'hFF) state_nxt = KSA_A;
         end
         KSA_A: begin
            addr_c    = i;
            state_nxt = KSA_B;
         end
         KSA_B: begin
            addr_c    = j_ksa;
            state_nxt = KSA_C;
         end
         KSA_C: begin
            addr_c    = i;
            we_c      = 1'b1;
            wdata_c   = bus.sbox_rdata;
            state_nxt = KSA_D;
         end
         KSA_D: begin
            addr_c    = j;
            we_c      = 1'b1;
            wdata_c   = si;
            state_nxt = (i == 8'hFF) ? READY : KSA_A;
         end
         READY: begin
            if (start_ok)             state_nxt = LOAD;
            else if (bus.data_rvalid) state_nxt = P1;
         end
         P1: begin
            addr_c    = i + 8'd1;
            state_nxt = P2;
         end
         P2: begin
            addr_c    = j_prga;
            state_nxt = P3;
         end
         P3: begin
            addr_c    = i;
            we_c      = 1'b1;
            wdata_c   = bus.sbox_rdata;
            state_nxt = P4;
         end
         P4: begin
            addr_c    = j;
            we_c      = 1'b1;
            wdata_c   = si;
            state_nxt = P5;
         end
         P5: begin
            addr_c    = si + sj;
            state_nxt = P6;
         end
         P6:    state_nxt = P_OUT;
         P_OUT: if (bus.data_wready) state_nxt = READY;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i     <= 8'd0;
         j     <= 8'd0;
         si    <= 8'd0;
         sj    <= 8'd0;
         kidx  <= '0;
         len   <= 9'd0;
         din   <= 8'd0;
         dout  <= 8'd0;
         ready <= 1'b0;
         err   <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
         err <= 1'b0;
         case (state)
            IDLE, READY: begin
               if (start && !len_ok) err <= 1'b1;
               if (start_ok) begin
                  len   <= key_len;
                  ready <= 1'b0;
                  i     <= 8'd0;
                  j     <= 8'd0;
                  kidx  <= '0;
               end else if (state == READY && bus.data_rvalid) begin
                  din <= bus.data_in;
               end
            end
            LOAD:  if (key_fire) kidx <= key_last ? '0 : kidx + KW'(1);
            INIT:  i <= i + 8'd1;
            KSA_B: begin
               si <= bus.sbox_rdata;
               j  <= j_ksa;
            end
            KSA_D: begin
               i    <= i + 8'd1;
               kidx <= key_last ? '0 : kidx + KW'(1);
               if (i == 8'hFF) begin
                  j     <= 8'd0;
                  ready <= 1'b1;
               end
            end
            P1: i <= i + 8'd1;
            P2: begin
               si <= bus.sbox_rdata;
               j  <= j_prga;
            end
            P3: sj   <= bus.sbox_rdata;
            P6: dout <= din ^ bus.sbox_rdata;
            default: ;
         endcase
      end
   end

   // NOTE: key storage has no reset; it is always rewritten by LOAD before KSA reads it.
   always_ff @(posedge clk) begin
      if (key_fire) key_buf[kidx] <= bus.key_in;
   end

   assign bus.key_rready  = (state == LOAD);
   assign bus.data_rready = (state == READY) && !start_ok;
   assign bus.data_wvalid = (state == P_OUT);
   assign bus.data_out    = dout;
   assign bus.sbox_addr   = addr_c;
   assign bus.sbox_we     = we_c;
   assign bus.sbox_wdata  = wdata_c;

endmodule

// File: tb/tb_rc4_sched.sv
// Bench for rc4_sched: S-box RAM model, known-answer vector table, abort/err/
// backpressure sequences and randomized keys/data against a plain RC4 model.
module tb_rc4_sched;
   localparam int KEY_MAX = 16;
   localparam int LATENCY = 1281;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [8:0] key_len;
   logic       ready, err;

   rc4_sched_if bus ();

   rc4_sched #(.KEY_MAX(KEY_MAX)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .key_len (key_len),
      .ready   (ready),
      .err     (err),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read S-box RAM
   logic [7:0] ram [256];
   always @(posedge clk) begin
      if (bus.sbox_we) ram[bus.sbox_addr] <= bus.sbox_wdata;
      else             bus.sbox_rdata     <= ram[bus.sbox_addr];
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference RC4 model
   int         ms [256];
   int         mi, mj;
   logic [7:0] mkey [KEY_MAX];

   task automatic model_ksa(input int len);
      int t, y;
      for (int x = 0; x < 256; x++) ms[x] = x;
      y = 0;
      for (int x = 0; x < 256; x++) begin
         y = (y + ms[x] + int'(mkey[x % len])) % 256;
         t = ms[x]; ms[x] = ms[y]; ms[y] = t;
      end
      mi = 0;
      mj = 0;
   endtask

   task automatic model_byte(input logic [7:0] d, output logic [7:0] o);
      int t;
      mi = (mi + 1) % 256;
      mj = (mj + ms[mi]) % 256;
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      o = d ^ 8'(ms[(ms[mi] + ms[mj]) % 256]);
   endtask

   function automatic logic [31:0] out_vec();
      return {2'b00, bus.key_rready, bus.data_rready, bus.data_wvalid, bus.data_out,
              bus.sbox_addr, bus.sbox_we, bus.sbox_wdata, ready, err};
   endfunction

   // All stimulus is applied and sampled at negedges.
   task automatic feed_key(input int len);
      int cnt;
      start   = 1'b1;
      key_len = 9'(len);
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < len; n++) begin
         bus.key_rvalid = 1'b1;
         bus.key_in     = mkey[n];
         cnt = 0;
         while (!bus.key_rready && cnt < 50) begin
            @(negedge clk);
            cnt++;
         end
         if (cnt >= 50) check("key_rready_timeout", 32'(cnt), 0);
         @(negedge clk);
      end
      bus.key_rvalid = 1'b0;
   endtask

   task automatic load_key(input int len, output int cycles);
      feed_key(len);
      cycles = 1;
      while (!ready && cycles < 3000) begin
         @(negedge clk);
         cycles++;
      end
      model_ksa(len);
   endtask

   task automatic encrypt(input logic [7:0] d, input int delay, output logic [7:0] o);
      int cnt, bad;
      logic [7:0] first;
      bus.data_rvalid = 1'b1;
      bus.data_in     = d;
      cnt = 0;
      while (!bus.data_rready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 50) check("data_rready_timeout", 32'(cnt), 0);
      @(negedge clk);
      bus.data_rvalid = 1'b0;
      cnt = 0;
      while (!bus.data_wvalid && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 50) check("data_wvalid_timeout", 32'(cnt), 0);
      first = bus.data_out;
      bad = 0;
      repeat (delay) begin
         @(negedge clk);
         if (bus.data_out !== first || !bus.data_wvalid || bus.data_rready || bus.sbox_we) bad++;
      end
      if (delay > 0) check("backpressure_hold", 32'(bad), 0);
      o = first;
      bus.data_wready = 1'b1;
      @(negedge clk);
      bus.data_wready = 1'b0;
   endtask

   typedef struct {
      logic [127:0] key;
      int           klen;
      logic [127:0] pt;
      logic [127:0] ct;
      int           plen;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         cycles, bad, len;
      logic [7:0] o, m, d;
      logic [127:0] kv, pv, cv;
      int         bad_lens [2];

      vecs[0].key = "Key";    vecs[0].klen = 3; vecs[0].pt = "Plaintext";      vecs[0].plen = 9;
      vecs[0].ct  = 128'hBBF316E8D940AF0AD3;
      vecs[1].key = "Key";    vecs[1].klen = 3; vecs[1].pt = '0;               vecs[1].plen = 10;
      vecs[1].ct  = 128'hEB9F7781B734CA72A719;
      vecs[2].key = "Wiki";   vecs[2].klen = 4; vecs[2].pt = "pedia";          vecs[2].plen = 5;
      vecs[2].ct  = 128'h1021BF0420;
      vecs[3].key = "Secret"; vecs[3].klen = 6; vecs[3].pt = "Attack at dawn"; vecs[3].plen = 14;
      vecs[3].ct  = 128'h45A01F645FC35B383552544B9BF5;
      bad_lens[0] = 0;
      bad_lens[1] = KEY_MAX + 1;

      start = 1'b0; key_len = 9'd0;
      bus.key_rvalid = 1'b0; bus.key_in = 8'd0;
      bus.data_rvalid = 1'b0; bus.data_in = 8'd0; bus.data_wready = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", out_vec(), 0);
      rst = 1'b1;
      @(negedge clk);

      // Bad length from IDLE
      start = 1'b1; key_len = 9'd0;
      @(negedge clk);
      start = 1'b0;
      check("idle_err_pulse", 32'(err), 1);
      check("idle_err_ready", 32'(ready), 0);
      check("idle_err_key_rready", 32'(bus.key_rready), 0);
      @(negedge clk);
      check("idle_err_clears", 32'(err), 0);
      check("idle_err_no_load", 32'(bus.key_rready), 0);

      // Abort mid-KSA
      mkey[0] = 8'h4B; mkey[1] = 8'h65; mkey[2] = 8'h79;
      feed_key(3);
      repeat (600) @(negedge clk);
      check("ksa_not_ready", 32'(ready), 0);
      rst = 1'b0;
      #1;
      check("abort_outputs", out_vec(), 0);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.sbox_we || ready || bus.key_rready || err) bad++;
      end
      check("idle_after_abort", 32'(bad), 0);

      // Known-answer table; the last entry restarts from READY
      for (int v = 0; v < 4; v++) begin
         kv = vecs[v].key; pv = vecs[v].pt; cv = vecs[v].ct;
         for (int n = 0; n < vecs[v].klen; n++) mkey[n] = kv[(vecs[v].klen - 1 - n) * 8 +: 8];
         load_key(vecs[v].klen, cycles);
         check($sformatf("kat%0d_latency", v), 32'(cycles), LATENCY);
         for (int b = 0; b < vecs[v].plen; b++) begin
            encrypt(pv[(vecs[v].plen - 1 - b) * 8 +: 8], 0, o);
            model_byte(pv[(vecs[v].plen - 1 - b) * 8 +: 8], m);
            check($sformatf("kat%0d_b%0d", v, b), 32'(o), 32'(cv[(vecs[v].plen - 1 - b) * 8 +: 8]));
         end
      end

      // Bad length from READY
      for (int k = 0; k < 2; k++) begin
         start = 1'b1; key_len = 9'(bad_lens[k]);
         @(negedge clk);
         start = 1'b0;
         check($sformatf("ready_err_pulse_%0d", bad_lens[k]), 32'(err), 1);
         check($sformatf("ready_err_ready_%0d", bad_lens[k]), 32'(ready), 1);
         check($sformatf("ready_err_key_rready_%0d", bad_lens[k]), 32'(bus.key_rready), 0);
         @(negedge clk);
         check($sformatf("ready_err_clears_%0d", bad_lens[k]), 32'(err), 0);
      end
      encrypt(8'h5A, 0, o);
      model_byte(8'h5A, m);
      check("after_err_byte", 32'(o), 32'(m));

      // Backpressure
      encrypt(8'hC3, 20, o);
      model_byte(8'hC3, m);
      check("backpressure_byte", 32'(o), 32'(m));

      // Random keys and data
      for (int r = 0; r < 4; r++) begin
         len = (r == 0) ? 1 : (r == 1) ? KEY_MAX : int'($urandom_range(2, KEY_MAX - 1));
         for (int n = 0; n < len; n++) mkey[n] = 8'($urandom);
         load_key(len, cycles);
         check($sformatf("rnd%0d_latency", r), 32'(cycles), LATENCY);
         for (int b = 0; b < 12; b++) begin
            d = 8'($urandom);
            encrypt(d, int'($urandom_range(0, 3)), o);
            model_byte(d, m);
            check($sformatf("rnd%0d_b%0d", r, b), 32'(o), 32'(m));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
